// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared FSM type and width helpers for the bit-serial sequence-detect path.
package seq_det_pkg;

    // Serialiser FSM: waiting for a word, or streaming one out MSB-first.
    typedef enum logic [0:0] {
        StIdle,
        StShift
    } state_e;

    // Width of a pattern-length field: must hold 0..pat_max inclusive.
    function automatic int unsigned len_w(input int unsigned pat_max);
        return $clog2(pat_max) + 1;
    endfunction

    // Width of the bit index within a word (0 = MSB).
    function automatic int unsigned bitcnt_w(input int unsigned word_w);
        return (word_w > 2) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/seq_det_matcher.sv
// seq_det_matcher: rolling history of received bits compared against a programmable
// pattern. The newest bit sits at bit 0 of the compare window. match is combinational
// on the bit being presented this cycle.
module seq_det_matcher
    import seq_det_pkg::*;
#(
    parameter int unsigned PAT_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      bit_in,
    input  logic                      bit_vld,
    input  logic [len_w(PAT_MAX)-1:0] len,
    input  logic [PAT_MAX-1:0]        pattern,
    input  logic                      overlap,
    input  logic                      flush,
    output logic                      match
);

    localparam int unsigned LEN_W = len_w(PAT_MAX);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_MAX);

    logic [PAT_MAX-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W:0]     fill_inc;

    // Compare window: history shifted up with the current bit as the newest entry.
    always_comb begin
        window = (hist_q << 1) | PAT_MAX'(bit_in);
        mask   = '0;
        for (int i = 0; i < int'(PAT_MAX); i++) begin
            mask[i] = (LEN_W'(i) < len);
        end
        fill_inc = {1'b0, fill_q} + 1'b1;
        // fill+1 >= len keeps stale bits from before a clear out of the compare.
        match = bit_vld && (len != '0) && (((window ^ pattern) & mask) == '0) &&
                (fill_inc >= {1'b0, len});
    end

    // History/fill next state; a flush wins over the update on the same cycle.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (bit_vld) begin
            hist_d = window;
            if (match && !overlap) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
        if (flush) begin
            hist_d = '0;
            fill_d = '0;
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_det_stream_ctrl.sv
// seq_det_stream_ctrl: accepts words over valid/ready, serialises them MSB-first at one
// bit per cycle into seq_det_matcher, counts matches and raises a sticky threshold irq.
// Optional: define SEQ_DET_BITPOS_EN to add det_bitpos (index of the completing bit).
module seq_det_stream_ctrl
    import seq_det_pkg::*;
#(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned PAT_MAX = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [PAT_MAX-1:0]          cfg_pattern,
    input  logic [len_w(PAT_MAX)-1:0]   cfg_len,
    input  logic                        cfg_overlap,
    input  logic                        s_valid,
    input  logic [WORD_W-1:0]           s_data,
    output logic                        s_ready,
    output logic                        det_pulse,
    output logic [CNT_W-1:0]            match_cnt,
    input  logic [CNT_W-1:0]            cnt_thresh,
    input  logic                        clr_cnt,
    output logic                        irq,
`ifdef SEQ_DET_BITPOS_EN
    output logic [bitcnt_w(WORD_W)-1:0] det_bitpos,
`endif
    output logic                        busy
);

    localparam int unsigned LEN_W    = len_w(PAT_MAX);
    localparam int unsigned BITCNT_W = bitcnt_w(WORD_W);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(WORD_W - 1);
    localparam logic [LEN_W-1:0]    LEN_MAX  = LEN_W'(PAT_MAX);
    localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;

    logic                enable_q;
    logic [PAT_MAX-1:0]  lat_pattern_q;
    logic [LEN_W-1:0]    lat_len_q;
    logic                lat_overlap_q;

    logic                det_pulse_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                irq_q, irq_d;

    logic                bit_vld;
    logic                flush;
    logic                match;
    logic                cfg_rise;

    assign cfg_rise = enable && !enable_q;

    // Serialiser FSM: next state, shift register, handshake and matcher flush.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        s_ready  = 1'b0;
        bit_vld  = 1'b0;
        flush    = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_ready = enable && !rst;
                // History only survives idle gaps while the stream stays enabled.
                flush   = !enable;
                if (s_valid && s_ready) begin
                    shreg_d  = s_data;
                    bitcnt_d = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                bit_vld  = 1'b1;
                shreg_d  = shreg_q << 1;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    s_ready = enable && !rst;
                    if (s_valid && s_ready) begin
                        // Reload on the last bit keeps the stream gapless.
                        shreg_d  = s_data;
                        bitcnt_d = '0;
                    end else begin
                        state_d = StIdle;
                        flush   = !enable;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM and serialiser registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            shreg_q  <= '0;
            bitcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
        end
    end

    // Config capture on the rising edge of enable; length clamped to PAT_MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q      <= 1'b0;
            lat_pattern_q <= '0;
            lat_len_q     <= '0;
            lat_overlap_q <= 1'b0;
        end else begin
            enable_q <= enable;
            if (cfg_rise) begin
                lat_pattern_q <= cfg_pattern;
                lat_len_q     <= (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
                lat_overlap_q <= cfg_overlap;
            end
        end
    end

    seq_det_matcher #(
        .PAT_MAX (PAT_MAX)
    ) u_matcher (
        .clk     (clk),
        .rst     (rst),
        .bit_in  (shreg_q[WORD_W-1]),
        .bit_vld (bit_vld),
        .len     (lat_len_q),
        .pattern (lat_pattern_q),
        .overlap (lat_overlap_q),
        .flush   (flush),
        .match   (match)
    );

    // Saturating match counter and sticky irq; clear beats a coincident match.
    always_comb begin
        cnt_d = cnt_q;
        irq_d = irq_q;
        if (clr_cnt) begin
            cnt_d = '0;
            irq_d = 1'b0;
        end else if (match) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if ((cnt_thresh != '0) && (cnt_d >= cnt_thresh)) begin
                irq_d = 1'b1;
            end
        end
    end

    // Match strobe, counter and irq registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            det_pulse_q <= 1'b0;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
        end else begin
            det_pulse_q <= match;
            cnt_q       <= cnt_d;
            irq_q       <= irq_d;
        end
    end

`ifdef SEQ_DET_BITPOS_EN
    logic [BITCNT_W-1:0] bitpos_q;

    // Index of the bit that completed the most recent match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitpos_q <= '0;
        end else if (match) begin
            bitpos_q <= bitcnt_q;
        end
    end

    assign det_bitpos = bitpos_q;
`endif

    assign det_pulse = det_pulse_q;
    assign match_cnt = cnt_q;
    assign irq       = irq_q;
    assign busy      = (state_q == StShift);

endmodule
